// File: rtl/ledpanel_pkg.sv
// Shared constants for the ledpanel configuration scheduler: register map,
// reset defaults, validation lower bounds and the scheduler state encoding.
package ledpanel_pkg;

  localparam int unsigned NUM_WORDS = 5;

  localparam logic [2:0] ADDR_ROWS       = 3'd0;
  localparam logic [2:0] ADDR_COLS       = 3'd1;
  localparam logic [2:0] ADDR_BITDEPTH   = 3'd2;
  localparam logic [2:0] ADDR_LSB_BLANK  = 3'd3;
  localparam logic [2:0] ADDR_BRIGHTNESS = 3'd4;

  localparam int unsigned DEF_N_ROWS_MAX    = 64;
  localparam int unsigned DEF_N_COLS_MAX    = 256;
  localparam int unsigned DEF_BITDEPTH_MAX  = 8;
  localparam int unsigned DEF_LSB_BLANK_MAX = 200;
  localparam int unsigned DEF_BRIGHTNESS    = 1;
  localparam int unsigned DEF_CTRL_WIDTH    = 32;
  localparam int unsigned DEF_RST_CYCLES    = 4;
  localparam int unsigned DEF_FRAME_TIMEOUT = 2**20;

  localparam int unsigned N_ROWS_MIN     = 2;
  localparam int unsigned N_COLS_MIN     = 1;
  localparam int unsigned BITDEPTH_MIN   = 1;
  localparam int unsigned LSB_BLANK_MIN  = 1;
  localparam int unsigned BRIGHTNESS_MIN = 1;

  typedef enum logic [1:0] {
    S_OFF,
    S_APPLY,
    S_RUN,
    S_WAIT
  } state_t;

endpackage

// File: rtl/ledpanel_cfg_check.sv
// Combinational validator for one ledpanel configuration set.
module ledpanel_cfg_check
  import ledpanel_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH    = DEF_CTRL_WIDTH,
  parameter int unsigned N_ROWS_MAX    = DEF_N_ROWS_MAX,
  parameter int unsigned N_COLS_MAX    = DEF_N_COLS_MAX,
  parameter int unsigned BITDEPTH_MAX  = DEF_BITDEPTH_MAX,
  parameter int unsigned LSB_BLANK_MAX = DEF_LSB_BLANK_MAX
) (
  input  logic [CTRL_WIDTH-1:0] n_rows,
  input  logic [CTRL_WIDTH-1:0] n_cols,
  input  logic [CTRL_WIDTH-1:0] bitdepth,
  input  logic [CTRL_WIDTH-1:0] lsb_blank,
  input  logic [CTRL_WIDTH-1:0] brightness,
  output logic                  valid
);

  logic rows_ok, cols_ok, depth_ok, blank_ok, bright_ok;

  always_comb begin
    // rows are scanned in pairs, so an odd count is never legal
    rows_ok   = !n_rows[0] &&
                (n_rows >= CTRL_WIDTH'(N_ROWS_MIN)) &&
                (n_rows <= CTRL_WIDTH'(N_ROWS_MAX));
    cols_ok   = (n_cols >= CTRL_WIDTH'(N_COLS_MIN)) &&
                (n_cols <= CTRL_WIDTH'(N_COLS_MAX));
    depth_ok  = (bitdepth >= CTRL_WIDTH'(BITDEPTH_MIN)) &&
                (bitdepth <= CTRL_WIDTH'(BITDEPTH_MAX));
    blank_ok  = (lsb_blank >= CTRL_WIDTH'(LSB_BLANK_MIN)) &&
                (lsb_blank <= CTRL_WIDTH'(LSB_BLANK_MAX));
    bright_ok = (brightness >= CTRL_WIDTH'(BRIGHTNESS_MIN)) &&
                (brightness <= lsb_blank);
    valid     = rows_ok && cols_ok && depth_ok && blank_ok && bright_ok;
  end

endmodule

// File: rtl/ledpanel_cfg_sched.sv
// Holds shadow/pending/active ledpanel config and applies a validated set only
// at a frame boundary by pulsing panel_rst with panel_en low.
module ledpanel_cfg_sched
  import ledpanel_pkg::*;
#(
  parameter int unsigned N_ROWS_MAX    = DEF_N_ROWS_MAX,
  parameter int unsigned N_COLS_MAX    = DEF_N_COLS_MAX,
  parameter int unsigned BITDEPTH_MAX  = DEF_BITDEPTH_MAX,
  parameter int unsigned LSB_BLANK_MAX = DEF_LSB_BLANK_MAX,
  parameter int unsigned CTRL_WIDTH    = DEF_CTRL_WIDTH,
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  ctrl_rst_n,
  input  logic                  host_en,
  input  logic                  cfg_wr_en,
  input  logic [2:0]            cfg_wr_addr,
  input  logic [CTRL_WIDTH-1:0] cfg_wr_data,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic                  panel_mem_buffer,
  output logic                  panel_en,
  output logic                  panel_rst,
  output logic [CTRL_WIDTH-1:0] panel_n_rows,
  output logic [CTRL_WIDTH-1:0] panel_n_cols,
  output logic [CTRL_WIDTH-1:0] panel_bitdepth,
  output logic [CTRL_WIDTH-1:0] panel_lsb_blank,
  output logic [CTRL_WIDTH-1:0] panel_brightness,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FRAME_TIMEOUT - 1);

  typedef logic [CTRL_WIDTH-1:0] word_t;

  localparam word_t DFLT [NUM_WORDS] = '{
    word_t'(N_ROWS_MAX), word_t'(N_COLS_MAX), word_t'(BITDEPTH_MAX),
    word_t'(LSB_BLANK_MAX), word_t'(DEF_BRIGHTNESS)
  };

  word_t shadow  [NUM_WORDS];
  word_t pending [NUM_WORDS];
  word_t active  [NUM_WORDS];

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;
  logic             mb_q;
  logic             frame_edge;
  logic             cfg_valid;
  logic             commit_ok;
  logic             active_load;
  logic             active_from_shadow;
  logic             pend_load;

  ledpanel_cfg_check #(
    .CTRL_WIDTH   (CTRL_WIDTH),
    .N_ROWS_MAX   (N_ROWS_MAX),
    .N_COLS_MAX   (N_COLS_MAX),
    .BITDEPTH_MAX (BITDEPTH_MAX),
    .LSB_BLANK_MAX(LSB_BLANK_MAX)
  ) u_check (
    .n_rows    (shadow[ADDR_ROWS]),
    .n_cols    (shadow[ADDR_COLS]),
    .bitdepth  (shadow[ADDR_BITDEPTH]),
    .lsb_blank (shadow[ADDR_LSB_BLANK]),
    .brightness(shadow[ADDR_BRIGHTNESS]),
    .valid     (cfg_valid)
  );

  assign commit_ok  = cfg_commit && cfg_valid;
  assign panel_rst  = (state == S_APPLY);
  assign panel_en   = (state == S_RUN) || (state == S_WAIT);
  assign cfg_busy   = (state == S_WAIT);
  assign frame_edge = panel_en && (mb_q != panel_mem_buffer);

  assign panel_n_rows     = active[ADDR_ROWS];
  assign panel_n_cols     = active[ADDR_COLS];
  assign panel_bitdepth   = active[ADDR_BITDEPTH];
  assign panel_lsb_blank  = active[ADDR_LSB_BLANK];
  assign panel_brightness = active[ADDR_BRIGHTNESS];

  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    to_nxt             = to_cnt;
    active_load        = 1'b0;
    active_from_shadow = 1'b0;
    pend_load          = 1'b0;
    unique case (state)
      S_APPLY: begin
        // a commit while the panel is held in reset is taken as a fresh apply
        if (commit_ok) begin
          active_load        = 1'b1;
          active_from_shadow = 1'b1;
          cnt_nxt            = CNT_LOAD;
        end else if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = host_en ? S_RUN : S_OFF;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_OFF: begin
        if (commit_ok || host_en) begin
          state_nxt          = S_APPLY;
          cnt_nxt            = CNT_LOAD;
          active_load        = commit_ok;
          active_from_shadow = 1'b1;
        end
      end
      S_RUN: begin
        if (!host_en) begin
          if (commit_ok) begin
            state_nxt          = S_APPLY;
            cnt_nxt            = CNT_LOAD;
            active_load        = 1'b1;
            active_from_shadow = 1'b1;
          end else begin
            state_nxt = S_OFF;
          end
        end else if (commit_ok) begin
          pend_load = 1'b1;
          to_nxt    = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!host_en) begin
          state_nxt          = S_APPLY;
          cnt_nxt            = CNT_LOAD;
          active_load        = 1'b1;
          active_from_shadow = commit_ok;
        end else if (commit_ok) begin
          // the replacing commit swallows a coincident edge; timeout keeps running
          pend_load = 1'b1;
          if (to_cnt < TO_LAST) to_nxt = to_cnt + 1'b1;
        end else if (frame_edge || (to_cnt >= TO_LAST)) begin
          state_nxt   = S_APPLY;
          cnt_nxt     = CNT_LOAD;
          active_load = 1'b1;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_APPLY;
        cnt_nxt   = CNT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state     <= S_APPLY;
      cnt       <= CNT_LOAD;
      to_cnt    <= '0;
      mb_q      <= 1'b0;
      cfg_err   <= 1'b0;
      frame_cnt <= '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        shadow[i]  <= DFLT[i];
        pending[i] <= DFLT[i];
        active[i]  <= DFLT[i];
      end
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      to_cnt <= to_nxt;
      mb_q   <= panel_mem_buffer;
      if (cfg_commit) cfg_err <= !cfg_valid;
      if (state == S_APPLY)  frame_cnt <= '0;
      else if (frame_edge)   frame_cnt <= frame_cnt + 16'd1;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        if (cfg_wr_en && (cfg_wr_addr == 3'(i))) shadow[i] <= cfg_wr_data;
        if (pend_load) pending[i] <= shadow[i];
        if (active_load) active[i] <= active_from_shadow ? shadow[i] : pending[i];
      end
    end
  end

endmodule

// File: tb/tb_ledpanel_cfg_sched.sv
// Randomised scenario bench for ledpanel_cfg_sched with a rule-level model.
module tb_ledpanel_cfg_sched;

  localparam int unsigned W    = 32;
  localparam int unsigned RSTC = 4;
  localparam int unsigned TMO  = 100;

  logic          clk = 1'b0;
  logic          ctrl_rst_n, host_en, cfg_wr_en, cfg_commit;
  logic [2:0]    cfg_wr_addr;
  logic [W-1:0]  cfg_wr_data;
  logic          cfg_busy, cfg_err, panel_mem_buffer, panel_en, panel_rst;
  logic [W-1:0]  panel_n_rows, panel_n_cols, panel_bitdepth, panel_lsb_blank, panel_brightness;
  logic [15:0]   frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] dflt     [5] = '{32'd64, 32'd256, 32'd8, 32'd200, 32'd1};
  logic [W-1:0] m_shadow [5];
  logic [W-1:0] m_active [5];
  logic [W-1:0] m_pend   [5];

  always #5 clk = ~clk;

  ledpanel_cfg_sched #(.FRAME_TIMEOUT(TMO)) dut (
    .clk(clk), .ctrl_rst_n(ctrl_rst_n), .host_en(host_en),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .panel_mem_buffer(panel_mem_buffer), .panel_en(panel_en), .panel_rst(panel_rst),
    .panel_n_rows(panel_n_rows), .panel_n_cols(panel_n_cols),
    .panel_bitdepth(panel_bitdepth), .panel_lsb_blank(panel_lsb_blank),
    .panel_brightness(panel_brightness), .frame_cnt(frame_cnt)
  );

  function automatic bit rules_ok(input logic [W-1:0] s [5]);
    return (s[0] % 2 == 0) && (s[0] >= 2) && (s[0] <= 64) &&
           (s[1] >= 1) && (s[1] <= 256) && (s[2] >= 1) && (s[2] <= 8) &&
           (s[3] >= 1) && (s[3] <= 200) && (s[4] >= 1) && (s[4] <= s[3]);
  endfunction

  function automatic logic [5*W-1:0] dut_words();
    return {panel_n_rows, panel_n_cols, panel_bitdepth, panel_lsb_blank, panel_brightness};
  endfunction

  function automatic logic [5*W-1:0] pack(input logic [W-1:0] s [5]);
    return {s[0], s[1], s[2], s[3], s[4]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [W-1:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
    if (a < 5) m_shadow[a] = d;
  endtask

  task automatic write_set(input logic [W-1:0] s [5]);
    int unsigned off;
    off = $urandom_range(0, 4);
    for (int unsigned k = 0; k < 5; k++) write_word(3'((off + k) % 5), s[(off + k) % 5]);
  endtask

  task automatic gen_set(input bit force_legal, output logic [W-1:0] s [5]);
    bit lg;
    lg = force_legal || ($urandom_range(0, 3) != 0);
    s[0] = lg ? W'(2 * $urandom_range(1, 32)) : W'($urandom_range(0, 70));
    lg = force_legal || ($urandom_range(0, 3) != 0);
    s[1] = lg ? W'($urandom_range(1, 256)) : W'($urandom_range(0, 270));
    lg = force_legal || ($urandom_range(0, 3) != 0);
    s[2] = lg ? W'($urandom_range(1, 8)) : W'($urandom_range(0, 12));
    lg = force_legal || ($urandom_range(0, 3) != 0);
    s[3] = lg ? W'($urandom_range(1, 200)) : W'($urandom_range(0, 210));
    lg = force_legal || ($urandom_range(0, 3) != 0);
    if (lg && s[3] >= 1) s[4] = W'($urandom_range(1, int'(s[3])));
    else                 s[4] = W'($urandom_range(0, int'(s[3]) + 3));
  endtask

  task automatic commit(input bit toggle);
    cfg_commit = 1'b1;
    if (toggle) panel_mem_buffer = ~panel_mem_buffer;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_rst_drop(output int n);
    n = 0;
    while (panel_rst && n < 50) begin tick(); n++; end
  endtask

  task automatic test_reset();
    int n;
    ctrl_rst_n = 1'b0; host_en = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0;
    cfg_wr_data = '0; cfg_commit = 1'b0; panel_mem_buffer = 1'b0;
    m_shadow = dflt; m_active = dflt; m_pend = dflt;
    repeat (3) tick();
    n_cmp++; if ({panel_rst, panel_en, cfg_busy, cfg_err} !== 4'b1000) begin n_bad++;
      $display("FAIL reset_ctl: got %b want 1000", {panel_rst, panel_en, cfg_busy, cfg_err}); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++;
      $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL reset_words: got %h want %h", dut_words(), pack(m_active)); end
    ctrl_rst_n = 1'b1;
    wait_rst_drop(n);
    n_cmp++; if (n != RSTC) begin n_bad++;
      $display("FAIL reset_rst_len: got %0d want %0d", n, RSTC); end
    n_cmp++; if (panel_en !== 1'b1) begin n_bad++;
      $display("FAIL reset_run_en: got %b want 1", panel_en); end
  endtask

  task automatic test_apply_frame();
    int n;
    logic [W-1:0] s [5];
    s = '{32'd32, 32'd128, 32'd6, 32'd100, 32'd2};
    write_set(s);
    commit(1'b0);
    m_pend = m_shadow;
    n_cmp++; if ({cfg_busy, cfg_err, panel_rst} !== 3'b100) begin n_bad++;
      $display("FAIL apply_busy: got %b want 100", {cfg_busy, cfg_err, panel_rst}); end
    repeat ($urandom_range(1, 10)) tick();
    n_cmp++; if (cfg_busy !== 1'b1 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL apply_hold: busy %b words %h want busy 1 words %h", cfg_busy, dut_words(), pack(m_active)); end
    panel_mem_buffer = ~panel_mem_buffer;
    tick();
    m_active = m_pend;
    n_cmp++; if ({panel_rst, panel_en, cfg_busy} !== 3'b100) begin n_bad++;
      $display("FAIL apply_edge_ctl: got %b want 100", {panel_rst, panel_en, cfg_busy}); end
    n_cmp++; if (dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL apply_words: got %h want %h", dut_words(), pack(m_active)); end
    wait_rst_drop(n);
    n_cmp++; if (n != RSTC || panel_en !== 1'b1 || frame_cnt !== 16'd0) begin n_bad++;
      $display("FAIL apply_restart: len %0d en %b fc %0d want %0d 1 0", n, panel_en, frame_cnt, RSTC); end
    panel_mem_buffer = ~panel_mem_buffer;
    tick();
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++;
      $display("FAIL frame_cnt_1: got %0d want 1", frame_cnt); end
    panel_mem_buffer = ~panel_mem_buffer;
    repeat (3) tick();
    n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++;
      $display("FAIL frame_cnt_2: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_invalid();
    int n;
    write_word(3'd4, 32'd0);
    commit(1'b0);
    n_cmp++; if ({cfg_err, cfg_busy} !== 2'b10 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL bad_bright: err/busy %b words %h want 10 %h", {cfg_err, cfg_busy}, dut_words(), pack(m_active)); end
    write_word(3'd4, 32'd2);
    write_word(3'd0, 32'd33);
    commit(1'b0);
    n_cmp++; if ({cfg_err, cfg_busy, panel_en} !== 3'b101 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL bad_rows: err/busy/en %b words %h want 101 %h", {cfg_err, cfg_busy, panel_en}, dut_words(), pack(m_active)); end
    write_word(3'd0, 32'd16);
    commit(1'b0);
    m_pend = m_shadow;
    n_cmp++; if ({cfg_err, cfg_busy} !== 2'b01) begin n_bad++;
      $display("FAIL err_clear: got %b want 01", {cfg_err, cfg_busy}); end
    panel_mem_buffer = ~panel_mem_buffer;
    tick();
    m_active = m_pend;
    n_cmp++; if (dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL fixed_apply: got %h want %h", dut_words(), pack(m_active)); end
    wait_rst_drop(n);
  endtask

  task automatic test_timeout();
    int n;
    logic [W-1:0] s [5];
    gen_set(1'b1, s);
    write_set(s);
    commit(1'b0);
    m_pend = m_shadow;
    n = 0;
    while (!panel_rst && n < 300) begin tick(); n++; end
    m_active = m_pend;
    n_cmp++; if (n != TMO) begin n_bad++;
      $display("FAIL timeout_len: got %0d want %0d", n, TMO); end
    n_cmp++; if (dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL timeout_words: got %h want %h", dut_words(), pack(m_active)); end
    wait_rst_drop(n);
    n_cmp++; if (n != RSTC || panel_en !== 1'b1) begin n_bad++;
      $display("FAIL timeout_restart: len %0d en %b want %0d 1", n, panel_en, RSTC); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [W-1:0] s [5];
    gen_set(1'b1, s);
    write_set(s);
    commit(1'b1);
    m_pend = m_shadow;
    tick();
    n_cmp++; if ({cfg_busy, panel_rst} !== 2'b10 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL same_edge_commit: busy/rst %b words %h want 10 %h", {cfg_busy, panel_rst}, dut_words(), pack(m_active)); end
    gen_set(1'b1, s);
    s[0] = (m_pend[0] == 32'd2) ? 32'd4 : 32'd2;
    write_set(s);
    commit(1'b1);
    m_pend = m_shadow;
    tick();
    n_cmp++; if ({cfg_busy, panel_rst} !== 2'b10 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL busy_recommit: busy/rst %b words %h want 10 %h", {cfg_busy, panel_rst}, dut_words(), pack(m_active)); end
    panel_mem_buffer = ~panel_mem_buffer;
    tick();
    m_active = m_pend;
    n_cmp++; if (panel_rst !== 1'b1 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL second_set: rst %b words %h want 1 %h", panel_rst, dut_words(), pack(m_active)); end
    wait_rst_drop(n);
  endtask

  task automatic test_host_off();
    int n;
    logic [W-1:0] s [5];
    gen_set(1'b1, s);
    write_set(s);
    commit(1'b0);
    m_pend = m_shadow;
    host_en = 1'b0;
    tick();
    m_active = m_pend;
    n_cmp++; if ({panel_rst, cfg_busy} !== 2'b10 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL off_apply: rst/busy %b words %h want 10 %h", {panel_rst, cfg_busy}, dut_words(), pack(m_active)); end
    wait_rst_drop(n);
    repeat (3) tick();
    n_cmp++; if (n != RSTC || {panel_en, panel_rst} !== 2'b00) begin n_bad++;
      $display("FAIL off_state: len %0d en/rst %b want %0d 00", n, {panel_en, panel_rst}, RSTC); end
    gen_set(1'b1, s);
    write_set(s);
    commit(1'b0);
    m_active = m_shadow;
    n_cmp++; if (panel_rst !== 1'b1 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL off_commit: rst %b words %h want 1 %h", panel_rst, dut_words(), pack(m_active)); end
    wait_rst_drop(n);
    n_cmp++; if (panel_en !== 1'b0) begin n_bad++;
      $display("FAIL off_stays: en %b want 0", panel_en); end
    host_en = 1'b1;
    tick();
    wait_rst_drop(n);
    n_cmp++; if (n != RSTC || panel_en !== 1'b1 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL host_on: len %0d en %b want %0d 1", n, panel_en, RSTC); end
  endtask

  task automatic test_reset_mid_apply();
    int n;
    logic [W-1:0] s [5];
    gen_set(1'b1, s);
    s[1] = 32'd100;
    write_set(s);
    commit(1'b0);
    panel_mem_buffer = ~panel_mem_buffer;
    tick();
    tick();
    #1 ctrl_rst_n = 1'b0;
    #1;
    m_shadow = dflt; m_active = dflt; m_pend = dflt;
    n_cmp++; if ({panel_rst, cfg_busy, cfg_err} !== 3'b100 || dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL midrst_defaults: ctl %b words %h want 100 %h", {panel_rst, cfg_busy, cfg_err}, dut_words(), pack(m_active)); end
    ctrl_rst_n = 1'b1;
    wait_rst_drop(n);
    n_cmp++; if (n != RSTC) begin n_bad++;
      $display("FAIL midrst_len: got %0d want %0d", n, RSTC); end
    write_word(3'd0, 32'd16);
    commit(1'b0);
    m_pend = m_shadow;
    panel_mem_buffer = ~panel_mem_buffer;
    tick();
    m_active = m_pend;
    n_cmp++; if (dut_words() !== pack(m_active)) begin n_bad++;
      $display("FAIL midrst_shadow: got %h want %h", dut_words(), pack(m_active)); end
    wait_rst_drop(n);
  endtask

  task automatic test_random();
    int n;
    logic [W-1:0] s [5];
    for (int it = 0; it < 24; it++) begin
      gen_set(1'b0, s);
      write_set(s);
      write_word(3'($urandom_range(5, 7)), W'($urandom));
      commit(1'b0);
      if (rules_ok(m_shadow)) begin
        m_pend = m_shadow;
        n_cmp++; if ({cfg_busy, cfg_err} !== 2'b10) begin n_bad++;
          $display("FAIL rnd_accept[%0d]: busy/err %b want 10", it, {cfg_busy, cfg_err}); end
        repeat ($urandom_range(0, 5)) tick();
        panel_mem_buffer = ~panel_mem_buffer;
        tick();
        m_active = m_pend;
        n_cmp++; if (panel_rst !== 1'b1 || dut_words() !== pack(m_active)) begin n_bad++;
          $display("FAIL rnd_apply[%0d]: rst %b words %h want 1 %h", it, panel_rst, dut_words(), pack(m_active)); end
        wait_rst_drop(n);
      end else begin
        n_cmp++; if ({cfg_busy, cfg_err, panel_en} !== 3'b011 || dut_words() !== pack(m_active)) begin n_bad++;
          $display("FAIL rnd_reject[%0d]: busy/err/en %b words %h want 011 %h", it, {cfg_busy, cfg_err, panel_en}, dut_words(), pack(m_active)); end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_apply_frame();
    test_invalid();
    test_timeout();
    test_back_to_back();
    test_host_off();
    test_reset_mid_apply();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
